hub75_scan_ctrl: RTL
====================

# hub75_scan_ctrl

Parametrised HUB75/HUB75E scan controller with binary-coded-modulation (BCM) colour depth. It sits between the dual-port pixel RAM and the panel pins. Per row and per bit plane it reads one RAM word per column, extracts one bit per colour channel, shifts the bits out on `hub_ck`, latches them, then drives the output enable for a plane-weighted time. Column count, row-address width, colour depth and base on-time are configurable.

## Interface
Parameters:
- `COLS`, 64: columns per shift chain; must be ≤ 2**`COL_BITS`
- `COL_BITS`, 6: width of the column index
- `ROW_BITS`, 5: width of the row-select field (5 selects HUB75E A..E, 32 scan rows)
- `DEPTH`, 5: bits per colour channel, which is also the number of bit planes
- `SHOW_BASE`, 4: on-time of plane 0 in clocks; plane b is lit for `SHOW_BASE`<<b clocks

Ports:
- `clk` in 1: single clock domain
- `resetn` in 1: asynchronous, active-low reset
- `enable` in 1: run the scan; sampled only at plane boundaries
- `ram_rd` out 1: RAM read strobe
- `ram_addr` out `ROW_BITS+COL_BITS`: read address {row, col}
- `ram_data` in 6*`DEPTH`: {R1,G1,B1,R2,G2,B2}, each `DEPTH` bits with R1 at the MSBs; valid on the cycle after `ram_rd`
- `hub_rgb` out 6: {R1,G1,B1,R2,G2,B2} shift data
- `hub_ck` out 1: shift clock; data is sampled by the panel on the rising edge
- `hub_st` out 1: latch strobe, active high
- `hub_oe` out 1: blanking; 1 = LEDs off
- `hub_line` out `ROW_BITS`: row select (E,D,C,B,A)
- `frame_start` out 1: one-cycle pulse at the start of each frame

## Operation
- All outputs are registered. Reset values:
  - `hub_rgb`=0, `hub_ck`=0, `hub_st`=0, `hub_oe`=1
  - `hub_line`=0, `ram_rd`=0, `ram_addr`=0, `frame_start`=0
  - state IDLE; row, plane and column counters = 0
- States:
  - IDLE: `hub_oe`=1. Moves to SHIFT when `enable`=1.
  - SHIFT: `hub_oe`=1. Column c uses SHIFT cycles 2c..2c+3, overlapped with neighbouring columns:
    - cycle 2c: `ram_rd`=1, `ram_addr`={row,c}
    - cycle 2c+2: `hub_rgb` = bit[plane] of each channel, `hub_ck`=0
    - cycle 2c+3: `hub_ck`=1
    - SHIFT lasts 2*`COLS`+2 cycles and produces exactly `COLS` rising edges of `hub_ck`.
    - `ram_rd`=0 on odd cycles and after the last column.
  - LATCH (1 cycle): `hub_st`=1, `hub_ck`=0, `hub_oe`=1, `hub_line` is set to the row just shifted.
    - `frame_start`=1 in this cycle when row=0 and plane=0.
  - SHOW: `hub_oe`=0 for exactly `SHOW_BASE`<<plane cycles, then the counters advance:
    - plane+1; if plane was `DEPTH`-1, plane returns to 0 and row+1.
    - Row wraps from 2**`ROW_BITS`-1 to 0.
    - Next state is SHIFT if `enable`=1, otherwise IDLE.
- Plane order is LSB first (plane 0 = weight 1).
- `enable` dropped mid-plane: the current SHIFT/LATCH/SHOW completes, then IDLE. Row and plane counters are held. Re-enable resumes at the held plane; a frame is not restarted.
- `resetn` low at any time: immediate return to the reset values, including mid-SHOW, so `hub_oe` goes to 1 asynchronously.
- Columns ≥ `COLS` are never addressed.

## Timing
- Plane period = 2*`COLS`+3+(`SHOW_BASE`<<b) clocks.
- Defaults:
  - row period = 5*131+4*31 = 779 clocks
  - frame period = 32*779 = 24928 clocks
  - `frame_start` pulses are spaced exactly 24928 clocks apart while `enable`=1
- RAM read latency is fixed at 1 cycle; no back-pressure.
- `hub_rgb` is stable for the full high phase of `hub_ck` and one cycle before it (setup).
- `hub_st` is never asserted while `hub_oe`=0 or `hub_ck`=1.
- `hub_line` changes only in LATCH, i.e. only while `hub_oe`=1.
- First `ram_rd` occurs 1 cycle after `enable` is seen high in IDLE.

## Test plan
- Reset: hold `resetn`=0 with `enable`=1 → `hub_oe`=1, all other outputs 0. Release with `enable`=0 → stays IDLE, no `ram_rd` for 100 cycles.
- Small config (`COLS`=4, `ROW_BITS`=2, `DEPTH`=2, `SHOW_BASE`=2), `enable`=1:
  - `ram_addr` sequence per plane is {r,0..3}
  - 4 `hub_ck` rises per plane
  - one `hub_st` per plane
  - `hub_line` sequence 0,0,1,1,2,2,3,3,0
  - `frame_start` every 4*(11+2+11+4)=112 cycles
- Bit extraction (defaults): RAM returns R1=5'b10110, B2=5'b00001, others 0 → `hub_rgb` is 6'b000001, 6'b100000, 6'b100000, 6'b000000, 6'b100000 for planes 0..4.
- SHOW widths (defaults): `hub_oe`=0 runs measure 4, 8, 16, 32, 64 clocks; `frame_start` spacing is 24928.
- `enable` dropped mid-SHIFT of plane 2 → plane 2 completes its 16-cycle SHOW, then `hub_oe`=1 idle. Re-enable → first `ram_addr` is {same row,0} and the following SHOW is 32 cycles.
- `resetn` pulsed low mid-SHOW → `hub_oe`=1 before the next `clk` edge. After release, the scan restarts at row 0, plane 0 with `frame_start`.

Source files
------------

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl
//
// HUB75/HUB75E scan controller with binary-coded-modulation colour depth.
// For every row and every bit plane (LSB first) it reads one pixel-RAM word
// per column, picks the current plane's bit out of each of the six colour
// channels, shifts them into the panel on hub_ck, latches the row and then
// unblanks the LEDs for SHOW_BASE << plane clocks.
//
// Ports
//   clk          single clock
//   resetn       asynchronous active-low reset
//   enable       run the scan; only looked at on plane boundaries
//   ram_rd       pixel RAM read strobe
//   ram_addr     pixel RAM address {row, col}
//   ram_data     {R1,G1,B1,R2,G2,B2}, DEPTH bits each, valid one cycle after ram_rd
//   hub_rgb      {R1,G1,B1,R2,G2,B2} shift data
//   hub_ck       shift clock (panel samples on the rising edge)
//   hub_st       latch strobe, active high
//   hub_oe       blanking, 1 = LEDs off
//   hub_line     row select (E,D,C,B,A)
//   frame_start  one-cycle pulse at the latch of row 0, plane 0
module hub75_scan_ctrl #(
  parameter int COLS      = 64,
  parameter int COL_BITS  = 6,
  parameter int ROW_BITS  = 5,
  parameter int DEPTH     = 5,
  parameter int SHOW_BASE = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  output logic                         ram_rd,
  output logic [ROW_BITS+COL_BITS-1:0] ram_addr,
  input  logic [6*DEPTH-1:0]           ram_data,
  output logic [5:0]                   hub_rgb,
  output logic                         hub_ck,
  output logic                         hub_st,
  output logic                         hub_oe,
  output logic [ROW_BITS-1:0]          hub_line,
  output logic                         frame_start
);

  // Shift-cycle index runs 0 .. 2*COLS+1, one bit wider than 2*col.
  localparam int K_W      = COL_BITS + 2;
  localparam int PL_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SHOW_MAX = SHOW_BASE << (DEPTH - 1);
  localparam int SH_W     = $clog2(SHOW_MAX + 1);

  localparam logic [K_W-1:0]  K_LAST  = K_W'(2 * COLS + 1);
  localparam logic [PL_W-1:0] PL_LAST = PL_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, SHOW} state_t;

  state_t              state;
  logic [K_W-1:0]      k;
  logic [K_W-1:0]      k_nxt;
  logic [ROW_BITS-1:0] row;
  logic [ROW_BITS-1:0] row_nxt;
  logic [PL_W-1:0]     plane;
  logic [PL_W-1:0]     plane_nxt;
  logic [SH_W-1:0]     show_cnt;
  logic [SH_W-1:0]     show_load;
  logic [DEPTH-1:0]    chan;
  logic [5:0]          plane_bits;

  assign k_nxt     = k + 1'b1;
  // Loaded as length-1 so the SHOW state lasts exactly SHOW_BASE<<plane cycles.
  assign show_load = (SH_W'(SHOW_BASE) << plane) - 1'b1;

  always_comb begin
    plane_nxt = plane + 1'b1;
    row_nxt   = row;
    if (plane == PL_LAST) begin
      plane_nxt = '0;
      row_nxt   = row + 1'b1;
    end
  end

  // Channel i occupies ram_data[i*DEPTH +: DEPTH]; channel 0 is B2, so the
  // loop index lines up directly with the hub_rgb bit position.
  always_comb begin
    chan       = '0;
    plane_bits = '0;
    for (int i = 0; i < 6; i++) begin
      chan          = ram_data[i*DEPTH +: DEPTH];
      plane_bits[i] = chan[plane];
    end
  end

  // Every output is computed for the cycle after the current one, so the
  // decisions below use k_nxt (the shift cycle about to be presented).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      k           <= '0;
      row         <= '0;
      plane       <= '0;
      show_cnt    <= '0;
      ram_rd      <= 1'b0;
      ram_addr    <= '0;
      hub_rgb     <= '0;
      hub_ck      <= 1'b0;
      hub_st      <= 1'b0;
      hub_oe      <= 1'b1;
      hub_line    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          hub_oe <= 1'b1;
          if (enable) begin
            state    <= SHIFT;
            k        <= '0;
            ram_rd   <= 1'b1;
            ram_addr <= {row, COL_BITS'(0)};
          end
        end

        SHIFT: begin
          if (k == K_LAST) begin
            state       <= LATCH;
            ram_rd      <= 1'b0;
            hub_ck      <= 1'b0;
            hub_st      <= 1'b1;
            hub_line    <= row;
            frame_start <= (row == '0) && (plane == '0);
          end else begin
            k <= k_nxt;
            // Even cycles 2c issue the read for column c; RAM data for it
            // arrives in cycle 2c+1 and is presented on hub_rgb in 2c+2.
            ram_rd <= ~k_nxt[0] && (k_nxt[K_W-1:1] < (K_W-1)'(COLS));
            if (~k_nxt[0] && (k_nxt[K_W-1:1] < (K_W-1)'(COLS)))
              ram_addr <= {row, k_nxt[COL_BITS:1]};
            if (~k_nxt[0] && (k_nxt >= K_W'(2)))
              hub_rgb <= plane_bits;
            hub_ck <= k_nxt[0] && (k_nxt >= K_W'(3));
          end
        end

        LATCH: begin
          hub_st   <= 1'b0;
          hub_oe   <= 1'b0;
          show_cnt <= show_load;
          state    <= SHOW;
        end

        SHOW: begin
          if (show_cnt == '0) begin
            hub_oe <= 1'b1;
            plane  <= plane_nxt;
            row    <= row_nxt;
            if (enable) begin
              state    <= SHIFT;
              k        <= '0;
              ram_rd   <= 1'b1;
              ram_addr <= {row_nxt, COL_BITS'(0)};
            end else begin
              state <= IDLE;
            end
          end else begin
            show_cnt <= show_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
